// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: pixel type, default geometry and a small
// address-width helper used by the window generator and its line buffers.
package cnn_pkg;

    localparam int PIXEL_WIDTH     = 8;
    localparam int DEF_KERNEL_SIZE = 5;
    localparam int DEF_IMG_WIDTH   = 28;
    localparam int DEF_IMG_HEIGHT  = 28;

    typedef logic [PIXEL_WIDTH-1:0] pixel_t;

    // Counter/address width for a range of 'depth' values, never narrower than one bit.
    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of pixel storage. Reads are combinational so the stored column
// is available in the same cycle it is overwritten (read-before-write).
module conv_line_buffer
    import cnn_pkg::*;
#(
    parameter int WIDTH = PIXEL_WIDTH,
    parameter int DEPTH = DEF_IMG_WIDTH,
    localparam int AW   = addr_bits(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    // Contents are intentionally not reset; nothing reads them before they are rewritten.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/conv_window_generator.sv
// Turns a raster-order pixel stream into KERNEL_SIZE x KERNEL_SIZE sliding windows
// (stride 1, no padding) laid out to feed the PE pic[] port directly.
module conv_window_generator
    import cnn_pkg::*;
#(
    parameter int WIDTH       = PIXEL_WIDTH,
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pix_in,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic [WIDTH-1:0] window [KERNEL_SIZE*KERNEL_SIZE-1:0],
    output logic             window_valid,
    input  logic             window_ready,
    output logic             frame_done
);

    localparam int K  = KERNEL_SIZE;
    localparam int NB = K - 1;
    localparam int CW = addr_bits(IMG_WIDTH);
    localparam int RW = addr_bits(IMG_HEIGHT);

    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic             stall;
    logic             acc;
    logic             col_last;
    logic             row_last;
    logic             at_output;
    logic [WIDTH-1:0] lb_rdata [NB];
    logic [WIDTH-1:0] lb_wdata [NB];
    logic [WIDTH-1:0] new_col  [K];

    assign stall     = window_valid && !window_ready;
    assign pix_ready = !stall;
    assign acc       = pix_valid && pix_ready;
    assign col_last  = (col == CW'(IMG_WIDTH - 1));
    assign row_last  = (row == RW'(IMG_HEIGHT - 1));
    assign at_output = (row >= RW'(K - 1)) && (col >= CW'(K - 1));

    // Line buffers form a vertical shift chain: buffer 0 holds the previous row,
    // buffer NB-1 the oldest row still inside the window.
    for (genvar i = 0; i < NB; i++) begin : g_lb
        if (i == 0) begin : g_head
            assign lb_wdata[i] = pix_in;
        end else begin : g_tail
            assign lb_wdata[i] = lb_rdata[i-1];
        end

        conv_line_buffer #(
            .WIDTH (WIDTH),
            .DEPTH (IMG_WIDTH)
        ) u_line_buffer (
            .clk   (clk),
            .we    (acc),
            .addr  (col),
            .wdata (lb_wdata[i]),
            .rdata (lb_rdata[i])
        );
    end

    always_comb begin
        for (int r = 0; r < K - 1; r++) begin
            new_col[r] = lb_rdata[K-2-r];
        end
        new_col[K-1] = pix_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= acc && col_last && row_last;
            if (acc) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // A new window loads on every accepted pixel; valid follows only when the
    // bottom-right pixel sits at a position where the whole window is inside the image.
    always_ff @(posedge clk) begin
        if (rst) begin
            window_valid <= 1'b0;
            for (int j = 0; j < K * K; j++) begin
                window[j] <= '0;
            end
        end else if (acc) begin
            window_valid <= at_output;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    window[r*K+c] <= window[r*K+c+1];
                end
                window[r*K+K-1] <= new_col[r];
            end
        end else if (window_ready) begin
            window_valid <= 1'b0;
        end
    end

endmodule
